dmux_tx_pacer: RTL and testbench

- Source-side feeder for async_dmux.
- Accepts words from a core over a valid/ready handshake and buffers them in a small FIFO.
- Emits them as single-cycle val_d pulses with d held stable, spaced so the destination domain of async_dmux never misses or merges a transfer.
- async_dmux has no return acknowledge, so this block is the throttle on its source end.

---
 rtl/dmux_tx_pacer.sv | 110 +++++++++++
 tb/tb_dmux_tx_pacer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_tx_pacer.sv
// Source-side feeder for async_dmux: buffers core words in a small FIFO and replays them
// as single-cycle val_d strobes spaced at least GAP+1 cycles apart.
module dmux_tx_pacer #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int GAP   = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  output logic                   val_d,
  output logic [DW-1:0]          d,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] GAP_LOAD = 8'(GAP);

  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    gap_cnt;
  logic          push;
  logic          pop;
  logic          fire_slot;

  assign in_ready  = (level != LW'(DEPTH));
  assign push      = in_valid && in_ready;
  // A strobe may start from IDLE, on the last HOLD cycle, or back-to-back when GAP is zero.
  assign fire_slot = (state == IDLE)
                  || ((state == HOLD) && (gap_cnt <= 8'd1))
                  || ((state == FIRE) && (GAP == 0));
  assign pop       = fire_slot && (level != '0);
  assign busy      = (level != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // The pop edge is the edge that enters FIRE, so d and val_d load from the FIFO head together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      gap_cnt <= '0;
      val_d   <= 1'b0;
      d       <= '0;
    end else begin
      val_d <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state <= FIRE;
          end
        end
        FIRE: begin
          if (GAP == 0) begin
            state <= pop ? FIRE : IDLE;
          end else begin
            state   <= HOLD;
            gap_cnt <= GAP_LOAD;
          end
        end
        HOLD: begin
          gap_cnt <= (gap_cnt == 8'd0) ? 8'd0 : gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1) begin
            state <= pop ? FIRE : IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          gap_cnt <= '0;
        end
      endcase
      if (pop) begin
        val_d <= 1'b1;
        d     <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_dmux_tx_pacer.sv
// Bench for dmux_tx_pacer: a GAP=4 and a GAP=0 instance checked every cycle against a
// queue-based model of push order and minimum pulse spacing.
module tb_dmux_tx_pacer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int GAP_A = 4;
  localparam int GAP_B = 0;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid [2];
  logic          in_ready [2];
  logic [DW-1:0] in_data  [2];
  logic          val_d    [2];
  logic [DW-1:0] d        [2];
  logic [LW-1:0] level    [2];
  logic          busy     [2];

  always #5 clk = ~clk;

  dmux_tx_pacer #(.DW(DW), .DEPTH(DEPTH), .GAP(GAP_A)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .val_d(val_d[0]), .d(d[0]), .level(level[0]), .busy(busy[0])
  );

  dmux_tx_pacer #(.DW(DW), .DEPTH(DEPTH), .GAP(GAP_B)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .val_d(val_d[1]), .d(d[1]), .level(level[1]), .busy(busy[1])
  );

  // Model: words waiting in push order, and the earliest edge at which the next strobe may fire.
  logic [DW-1:0] mq  [2][$];
  logic [DW-1:0] obs [2][$];
  int            pe  [2][$];
  int            next_allowed [2];
  int            last_pulse   [2];
  logic          exp_val [2];
  logic [DW-1:0] exp_d   [2];
  int            edge_no;
  int            checks;
  int            errors;

  function automatic int gap_of(int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic bit will_fire(int i);
    return (mq[i].size() != 0) && (edge_no >= next_allowed[i]);
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("val_d[%0d]", i), DW'(val_d[i]), DW'(exp_val[i]));
      check($sformatf("d[%0d]", i), d[i], exp_d[i]);
      check($sformatf("level[%0d]", i), DW'(level[i]), DW'(mq[i].size()));
      check($sformatf("in_ready[%0d]", i), DW'(in_ready[i]), DW'(mq[i].size() != DEPTH));
      check($sformatf("busy[%0d]", i), DW'(busy[i]),
            DW'((mq[i].size() != 0) || (edge_no < next_allowed[i])));
      if (val_d[i] === 1'b1) begin
        obs[i].push_back(d[i]);
        pe[i].push_back(edge_no);
        if (last_pulse[i] >= 0) begin
          checks++;
          if (edge_no - last_pulse[i] < gap_of(i) + 1) begin
            errors++;
            $display("[TB] FAIL spacing[%0d]: got %0d cycles, expected at least %0d",
                     i, edge_no - last_pulse[i], gap_of(i) + 1);
          end
        end
        last_pulse[i] = edge_no;
      end
    end
  endtask

  // Advances the model across one rising edge using the inputs currently driven, then compares.
  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      bit rdy;
      rdy = (mq[i].size() != DEPTH);
      exp_val[i] = 1'b0;
      if (will_fire(i)) begin
        exp_val[i]      = 1'b1;
        exp_d[i]        = mq[i].pop_front();
        next_allowed[i] = edge_no + gap_of(i) + 1;
      end
      if (in_valid[i] && rdy) begin
        mq[i].push_back(in_data[i]);
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
    edge_no++;
  endtask

  task automatic doReset(int hold_edges);
    rstn     = 1'b0;
    in_valid = '{1'b0, 1'b0};
    #1;
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      next_allowed[i] = 0;
      last_pulse[i]   = -1;
      exp_val[i]      = 1'b0;
      exp_d[i]        = '0;
      check($sformatf("rst_val_d[%0d]", i), DW'(val_d[i]), 32'h0);
      check($sformatf("rst_d[%0d]", i), d[i], 32'h0);
      check($sformatf("rst_level[%0d]", i), DW'(level[i]), 32'h0);
      check($sformatf("rst_busy[%0d]", i), DW'(busy[i]), 32'h0);
    end
    repeat (hold_edges) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic clearLogs();
    for (int i = 0; i < 2; i++) begin
      obs[i].delete();
      pe[i].delete();
    end
  endtask

  initial begin
    int  nxt;
    int  pushed;
    int  full_fires;
    bit  acc;
    bit  ff;
    bit  chk_next;

    checks   = 0;
    errors   = 0;
    edge_no  = 0;
    rstn     = 1'b1;
    in_valid = '{1'b0, 1'b0};
    in_data  = '{32'h0, 32'h0};
    #2;
    doReset(2);

    // Single word: strobe on the edge after the push, d held, busy for GAP more cycles.
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h1;
    applyStimulus();
    in_valid[0] = 1'b0;
    applyStimulus();
    check("s1_val_pulse", DW'(val_d[0]), 32'h1);
    check("s1_d_pulse", d[0], 32'h1);
    applyStimulus();
    check("s1_val_after", DW'(val_d[0]), 32'h0);
    check("s1_d_hold", d[0], 32'h1);
    repeat (3) applyStimulus();
    check("s1_busy_hold", DW'(busy[0]), 32'h1);
    applyStimulus();
    check("s1_busy_drop", DW'(busy[0]), 32'h0);

    // Burst of 15 words with in_valid held high.
    clearLogs();
    nxt = 1;
    full_fires = 0;
    for (int c = 0; c < 90; c++) begin
      in_valid[0] = (nxt <= 15);
      in_data[0]  = DW'(nxt);
      acc = in_valid[0] && (mq[0].size() != DEPTH);
      applyStimulus();
      if (acc) nxt++;
      if (level[0] == LW'(DEPTH) && in_ready[0] == 1'b0) full_fires++;
    end
    in_valid[0] = 1'b0;
    check("s2_pulse_count", DW'(obs[0].size()), 32'd15);
    check("s2_full_seen", DW'(full_fires > 0), 32'h1);
    for (int k = 0; k < obs[0].size(); k++) begin
      check($sformatf("s2_order_%0d", k), obs[0][k], DW'(k + 1));
    end
    for (int k = 1; k < pe[0].size(); k++) begin
      check($sformatf("s2_period_%0d", k), DW'(pe[0][k] - pe[0][k-1]), 32'd5);
    end

    // GAP=0 instance: three words give three consecutive strobes.
    clearLogs();
    for (int k = 0; k < 3; k++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = 32'hA1 + DW'(k);
      applyStimulus();
    end
    in_valid[1] = 1'b0;
    repeat (4) applyStimulus();
    check("s3_pulse_count", DW'(obs[1].size()), 32'd3);
    for (int k = 0; k < obs[1].size(); k++) begin
      check($sformatf("s3_order_%0d", k), obs[1][k], 32'hA1 + DW'(k));
    end
    for (int k = 1; k < pe[1].size(); k++) begin
      check($sformatf("s3_back_to_back_%0d", k), DW'(pe[1][k] - pe[1][k-1]), 32'd1);
    end
    check("s3_level_empty", DW'(level[1]), 32'h0);

    // Hold level at 2 while pushing only on pop edges, wrapping the pointers.
    clearLogs();
    for (int k = 0; k < 3; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'h100 + DW'(k);
      applyStimulus();
    end
    pushed = 0;
    for (int c = 0; c < 70; c++) begin
      in_valid[0] = will_fire(0) && (pushed < 10);
      in_data[0]  = 32'h103 + DW'(pushed);
      acc = in_valid[0];
      applyStimulus();
      if (acc) begin
        pushed++;
        check($sformatf("s4_level_simul_%0d", pushed), DW'(level[0]), 32'd2);
      end
    end
    in_valid[0] = 1'b0;
    check("s4_pushed", DW'(pushed), 32'd10);
    check("s4_pulse_count", DW'(obs[0].size()), 32'd13);
    for (int k = 0; k < obs[0].size(); k++) begin
      check($sformatf("s4_order_%0d", k), obs[0][k], 32'h100 + DW'(k));
    end

    // Reset while three words wait in HOLD: everything clears, no strobe afterwards.
    for (int k = 0; k < 4; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'h200 + DW'(k);
      applyStimulus();
    end
    in_valid[0] = 1'b0;
    check("s5_level_before", DW'(level[0]), 32'd3);
    check("s5_d_before", d[0], 32'h200);
    doReset(2);
    clearLogs();
    repeat (20) applyStimulus();
    check("s5_no_pulse_a", DW'(obs[0].size()), 32'd0);
    check("s5_no_pulse_b", DW'(obs[1].size()), 32'd0);

    // Full FIFO at a pop edge: the held word is taken on the following edge.
    clearLogs();
    nxt = 0;
    full_fires = 0;
    chk_next = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'h300 + DW'(nxt);
      acc = (mq[0].size() != DEPTH);
      ff  = (mq[0].size() == DEPTH) && will_fire(0);
      applyStimulus();
      if (acc) nxt++;
      if (chk_next) check("s6_refill_level", DW'(level[0]), DW'(DEPTH));
      chk_next = 1'b0;
      if (ff) begin
        full_fires++;
        check("s6_pop_level", DW'(level[0]), DW'(DEPTH - 1));
        check("s6_ready_after_pop", DW'(in_ready[0]), 32'h1);
        chk_next = 1'b1;
      end
    end
    in_valid[0] = 1'b0;
    repeat (30) applyStimulus();
    check("s6_full_pops_seen", DW'(full_fires > 0), 32'h1);
    check("s6_pulse_count", DW'(obs[0].size()), DW'(nxt));
    for (int k = 0; k < obs[0].size(); k++) begin
      check($sformatf("s6_order_%0d", k), obs[0][k], 32'h300 + DW'(k));
    end

    // Random traffic on both instances with occasional resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset(1);
      end
      in_valid[0] = ($urandom_range(0, 99) < 60);
      in_valid[1] = ($urandom_range(0, 99) < 40);
      in_data[0]  = $urandom;
      in_data[1]  = $urandom;
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
